conv_input_packer: RTL and testbench
====================================

# conv_input_packer

Streaming-to-parallel front end for the generic convolution layer. It accepts one unsigned input element per accepted handshake, in channel-major, row-major order. It assembles the elements into the flat `MAX_IN_DATA_WIDTH` image bus that the convolution layer consumes, then issues a single-cycle valid pulse with the packed bus held stable. One frame is packed per `start` command, sized by runtime image dimensions.

## Interface
Parameters:
- `ELEM_WIDTH`, default 8, width of each element.
- `MAX_IMG_HEIGHT`, default 32, maximum image height.
- `MAX_IMG_WIDTH`, default 32, maximum image width.
- `MAX_IN_CHANNELS`, default 3, maximum input channels.
- `MAX_NUM_INPUT_ELEMENTS`, default `MAX_IN_CHANNELS*MAX_IMG_HEIGHT*MAX_IMG_WIDTH`, buffer capacity in elements.
- `MAX_IN_DATA_WIDTH`, default `MAX_NUM_INPUT_ELEMENTS*ELEM_WIDTH`, packed bus width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `abort`  in  1  synchronous frame abort.
- `img_height`  in  8  frame height; latched on accepted `start`.
- `img_width`  in  8  frame width; latched on accepted `start`.
- `in_channels`  in  8  frame channel count; latched on accepted `start`.
- `s_valid`  in  1  element valid.
- `s_data`  in  `ELEM_WIDTH`  element value, unsigned.
- `s_ready`  out  1  packer accepts an element this cycle.
- `valid_out`  out  1  one-cycle pulse: packed frame complete.
- `data_out`  out  `MAX_IN_DATA_WIDTH`  packed frame bus.
- `busy`  out  1  high in FILL and EMIT.
- `cfg_err`  out  1  one-cycle pulse: `start` rejected.

## Operation
- Frame size: `total = in_channels*img_height*img_width`, computed at 24 bits.
- **Element placement:** element k (k = 0..total-1) is written to `data_out[k*ELEM_WIDTH +: ELEM_WIDTH]`.
  - k = ch*H*W + row*W + col.
  - Element 0 occupies bits [ELEM_WIDTH-1:0].
  - Bits above total*ELEM_WIDTH are 0.
- **IDLE:** `s_ready`=0, `busy`=0.
  - On `start`=1, validate the config.
  - Reject if any dimension is 0, `img_height`>MAX_IMG_HEIGHT, `img_width`>MAX_IMG_WIDTH, or `in_channels`>MAX_IN_CHANNELS. On reject: `cfg_err`=1 for the next cycle, stay in IDLE, leave `data_out` unchanged.
  - Otherwise: latch config and total, clear `data_out` to 0, clear the element counter, go to FILL.
- **FILL:** `s_ready`=1, `busy`=1.
  - On `s_valid`&&`s_ready`: write `s_data` at the counter index, then increment the counter.
  - When the accepted element has index total-1, go to EMIT.
  - `s_valid`=0 stalls with no state change.
- **EMIT:** `s_ready`=0, `busy`=1, `valid_out`=1 for exactly this cycle; then go to IDLE.
- `data_out` holds the last packed frame until the next accepted `start` clears it.
- `start` is ignored outside IDLE.
- `abort`=1 in FILL or EMIT: return to IDLE next cycle, no `valid_out`, `data_out` retains partial contents. `abort` in IDLE is ignored.
- Simultaneous `abort` and the final accepted element: `abort` wins; the element is not written and no `valid_out` is issued.
- Counter width: 24 bits; it never exceeds total.

## Timing
- Reset values: `s_ready`=0, `valid_out`=0, `data_out`=0, `busy`=0, `cfg_err`=0; state IDLE.
- All outputs are registered.
- `start` accepted at cycle t: `busy`=1 and `s_ready`=1 from cycle t+1.
- Final element accepted at cycle k: `valid_out`=1 at cycle k+1, `s_ready`=0 at cycle k+1, IDLE at cycle k+2.
- A back-to-back `start` is first accepted at cycle k+2.
- Minimum frame time: total+2 cycles from `start` to `valid_out` deassertion.
- `rst_n` deasserted mid-frame: immediate return to reset values; partial frame discarded.

## Test plan
- **Basic frame:** H=2, W=2, C=1; stream 0x11,0x22,0x33,0x44 with `s_valid` held high → `valid_out` one cycle after 4th accept; `data_out[31:0]`=0x44332211; upper bits 0.
- **Multi-channel with stalls:** C=3, H=3, W=3; random `s_valid` gaps; stream values 0..26 → byte k equals k; `valid_out` exactly once; `s_ready` low during IDLE and EMIT.
- **Config reject:** `start` with `in_channels`=0, then `img_width`=33 → `cfg_err` pulse each time, `busy` stays 0, `data_out` unchanged.
- **Abort:** frame H=4, W=4, C=1; `abort` after 5 accepts → IDLE next cycle, no `valid_out`. A following full frame packs correctly from index 0.
- **Max frame:** C=3, H=32, W=32; 3072 elements → `valid_out` at accept+1; last byte at bits [24575:24568].
- **Reset mid-fill:** assert `rst_n`=0 after 10 accepts → all outputs 0 immediately; new `start` after release behaves as from reset.

Source files
------------

// File: rtl/conv_input_packer.sv
`default_nettype none
// ============================================================================
// Module  : conv_input_packer
// Packs a channel/row-major element stream into the flat convolution image bus.
// Revision: 1.0
// ============================================================================
module conv_input_packer #(
    parameter int ELEM_WIDTH             = 8,
    parameter int MAX_IMG_HEIGHT         = 32,
    parameter int MAX_IMG_WIDTH          = 32,
    parameter int MAX_IN_CHANNELS        = 3,
    parameter int MAX_NUM_INPUT_ELEMENTS = MAX_IN_CHANNELS * MAX_IMG_HEIGHT * MAX_IMG_WIDTH,
    parameter int MAX_IN_DATA_WIDTH      = MAX_NUM_INPUT_ELEMENTS * ELEM_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [7:0]                   img_height,
    input  logic [7:0]                   img_width,
    input  logic [7:0]                   in_channels,
    input  logic                         s_valid,
    input  logic [ELEM_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic                         valid_out,
    output logic [MAX_IN_DATA_WIDTH-1:0] data_out,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int C_IDX_W = $clog2(MAX_IN_DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [23:0]        r_cnt;
    logic [23:0]        r_total;

    logic [23:0]        w_total;
    logic               w_cfg_ok;
    logic               w_last;
    logic [C_IDX_W-1:0] w_bit_lo;

    assign w_total  = 24'(in_channels) * 24'(img_height) * 24'(img_width);

    assign w_cfg_ok = (in_channels != 8'd0) && (img_height != 8'd0) && (img_width != 8'd0) &&
                      (32'(img_height)  <= 32'(MAX_IMG_HEIGHT)) &&
                      (32'(img_width)   <= 32'(MAX_IMG_WIDTH))  &&
                      (32'(in_channels) <= 32'(MAX_IN_CHANNELS));

    assign w_last   = (r_cnt == (r_total - 24'd1));

    // Counter stays below total while filling, so the bit offset is always in range.
    assign w_bit_lo = C_IDX_W'({8'd0, r_cnt} * 32'(ELEM_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 24'd0;
            r_total   <= 24'd0;
            s_ready   <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= 1'b0;
            cfg_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_total  <= w_total;
                            r_cnt    <= 24'd0;
                            data_out <= '0;
                            s_ready  <= 1'b1;
                            busy     <= 1'b1;
                            r_state  <= S_FILL;
                        end else begin
                            cfg_err  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    // Abort takes priority, even over the final element.
                    if (abort) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (s_valid && s_ready) begin
                        data_out[w_bit_lo +: ELEM_WIDTH] <= s_data;
                        r_cnt <= r_cnt + 24'd1;
                        if (w_last) begin
                            s_ready   <= 1'b0;
                            valid_out <= 1'b1;
                            r_state   <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_input_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_input_packer
// Directed self-checking bench for conv_input_packer.
// Revision: 1.0
// ============================================================================
module tb_conv_input_packer;

    localparam int EW = 8;
    localparam int DW = 3 * 32 * 32 * EW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [7:0]    img_height;
    logic [7:0]    img_width;
    logic [7:0]    in_channels;
    logic          s_valid;
    logic [EW-1:0] s_data;
    logic          s_ready;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          cfg_err;

    logic [DW-1:0] exp_bus;
    int            n_checks = 0;
    int            n_errors = 0;
    int            vo_count = 0;
    int            vo_snap;

    conv_input_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .img_height  (img_height),
        .img_width   (img_width),
        .in_channels (in_channels),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out) vo_count <= vo_count + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] c, input logic [7:0] h, input logic [7:0] w);
        in_channels = c;
        img_height  = h;
        img_width   = w;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic send(input logic [EW-1:0] v, input int gaps);
        repeat (gaps) step();
        chk("s_ready_fill", s_ready, 1);
        s_valid = 1'b1;
        s_data  = v;
        step();
        s_valid = 1'b0;
    endtask

    // Called right after the final accept edge.
    task automatic frame_end(input string tag);
        chk({tag, "_valid_hi"}, valid_out, 1);
        chk({tag, "_ready_emit"}, s_ready, 0);
        chk({tag, "_busy_emit"}, busy, 1);
        step();
        chk({tag, "_valid_lo"}, valid_out, 0);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_ready_idle"}, s_ready, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        img_height = 8'd0; img_width = 8'd0; in_channels = 8'd0;
        s_valid = 1'b0; s_data = '0;
        repeat (3) step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_data", |data_out, 0);
        rst_n = 1'b1;
        step();

        // Basic 2x2x1 frame, back-to-back elements
        vo_snap = vo_count;
        do_start(8'd1, 8'd2, 8'd2);
        chk("basic_busy", busy, 1);
        chk("basic_ready", s_ready, 1);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        chk("basic_no_early_valid", valid_out, 0);
        send(8'h44, 0);
        chk("basic_word", data_out[31:0], 64'h44332211);
        chk("basic_upper", |data_out[DW-1:32], 0);
        frame_end("basic");
        chk("basic_pulses", vo_count - vo_snap, 1);

        // 3x3x3 frame with random stalls
        vo_snap = vo_count;
        exp_bus = '0;
        do_start(8'd3, 8'd3, 8'd3);
        for (int k = 0; k < 27; k++) begin
            exp_bus[k*EW +: EW] = EW'(k);
            send(EW'(k), $urandom_range(0, 3));
        end
        chk("multi_bus", data_out === exp_bus, 1);
        frame_end("multi");
        chk("multi_pulses", vo_count - vo_snap, 1);

        // Config rejects leave state and bus untouched
        do_start(8'd0, 8'd3, 8'd3);
        chk("rej_c0_err", cfg_err, 1);
        chk("rej_c0_busy", busy, 0);
        chk("rej_c0_ready", s_ready, 0);
        step();
        chk("rej_c0_err_pulse", cfg_err, 0);
        do_start(8'd1, 8'd4, 8'd33);
        chk("rej_w33_err", cfg_err, 1);
        chk("rej_w33_busy", busy, 0);
        step();
        chk("rej_w33_err_pulse", cfg_err, 0);
        chk("rej_bus_kept", data_out === exp_bus, 1);

        // Abort after 5 accepts in a 4x4x1 frame
        vo_snap = vo_count;
        do_start(8'd1, 8'd4, 8'd4);
        for (int k = 0; k < 5; k++) send(8'hA0 + 8'(k), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", s_ready, 0);
        chk("abort_valid", valid_out, 0);
        chk("abort_partial", data_out[39:0], 64'hA4A3A2A1A0);
        step();
        chk("abort_pulses", vo_count - vo_snap, 0);

        // Full frame after abort restarts at index 0
        do_start(8'd1, 8'd2, 8'd2);
        send(8'h55, 0); send(8'h66, 1); send(8'h77, 0); send(8'h88, 2);
        chk("post_abort_word", data_out[31:0], 64'h88776655);
        chk("post_abort_cleared", |data_out[DW-1:32], 0);
        frame_end("post_abort");

        // Abort coincident with the final element: abort wins
        vo_snap = vo_count;
        do_start(8'd1, 8'd1, 8'd1);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        step();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("abort_last_valid", valid_out, 0);
        chk("abort_last_busy", busy, 0);
        chk("abort_last_not_written", data_out[7:0], 64'h00);
        step();
        chk("abort_last_pulses", vo_count - vo_snap, 0);

        // Maximum 3x32x32 frame
        vo_snap = vo_count;
        exp_bus = '0;
        do_start(8'd3, 8'd32, 8'd32);
        for (int k = 0; k < 3072; k++) begin
            exp_bus[k*EW +: EW] = EW'(k * 7 + 3);
            send(EW'(k * 7 + 3), 0);
        end
        chk("max_bus", data_out === exp_bus, 1);
        chk("max_last_byte", data_out[24575:24568], 64'hFC);
        frame_end("max");
        chk("max_pulses", vo_count - vo_snap, 1);

        // Reset in the middle of a fill
        do_start(8'd2, 8'd2, 8'd3);
        for (int k = 0; k < 10; k++) send(8'h30 + 8'(k), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", s_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_cfg_err", cfg_err, 0);
        chk("mid_rst_data", |data_out, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle_busy", busy, 0);
        do_start(8'd1, 8'd1, 8'd1);
        chk("post_rst_ready", s_ready, 1);
        send(8'h5A, 0);
        chk("post_rst_byte", data_out[7:0], 64'h5A);
        chk("post_rst_upper", |data_out[DW-1:8], 0);
        frame_end("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
